nmr_seq_fsm: RTL and testbench

Parametrised successor to the single-pulse NMR acquisition sequencer. Runs a programmable multi-pulse excitation train: up to NUM_PULSES pulses, each with its own length, amplitude and post-pulse delay. Each train is followed by an acquisition window and a repetition-time (TR) pad, and the whole train repeats cfg_n_rep times. Sits between the PS config bus and the DDS generator / ADC writer / packetiser resets.

---
 rtl/nmr_seq_fsm_if.sv | 45 ++++
 rtl/nmr_seq_fsm.sv | 249 ++++++++++++++++++++++++
 tb/tb_nmr_seq_fsm.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nmr_seq_fsm_if.sv
// Config/control and generator/status bundle between the PS config bus and the NMR sequencer.
// master = config/status side, slave = sequencer.
interface nmr_seq_fsm_if #(
  parameter int CNT_W      = 32,
  parameter int NUM_PULSES = 4,
  parameter int IDX_W      = 3,
  parameter int REP_W      = 16
);
  logic                        start;
  logic                        abort;
  logic [IDX_W-1:0]            cfg_n_pulses;
  logic [NUM_PULSES*CNT_W-1:0] cfg_pulse_len;
  logic [NUM_PULSES*CNT_W-1:0] cfg_delay_len;
  logic [NUM_PULSES*16-1:0]    cfg_amp;
  logic [31:0]                 cfg_freq;
  logic [CNT_W-1:0]            cfg_acq_len;
  logic [CNT_W-1:0]            cfg_tr;
  logic [REP_W-1:0]            cfg_n_rep;

  logic                        en_gen;
  logic [15:0]                 gen_amp;
  logic [31:0]                 gen_freq;
  logic [1:0]                  gen_phase;
  logic                        rst_writer;
  logic                        rst_pck;
  logic                        busy;
  logic                        done;
  logic                        err;
  logic [REP_W-1:0]            rep_idx;
  logic [2:0]                  state;

  modport master (
    output start, abort, cfg_n_pulses, cfg_pulse_len, cfg_delay_len, cfg_amp,
           cfg_freq, cfg_acq_len, cfg_tr, cfg_n_rep,
    input  en_gen, gen_amp, gen_freq, gen_phase, rst_writer, rst_pck, busy,
           done, err, rep_idx, state
  );

  modport slave (
    input  start, abort, cfg_n_pulses, cfg_pulse_len, cfg_delay_len, cfg_amp,
           cfg_freq, cfg_acq_len, cfg_tr, cfg_n_rep,
    output en_gen, gen_amp, gen_freq, gen_phase, rst_writer, rst_pck, busy,
           done, err, rep_idx, state
  );
endinterface

// File: rtl/nmr_seq_fsm.sv
// Multi-pulse NMR excitation/acquisition sequencer with TR padding and repetitions.
// Optional macro NMR_SEQ_PHASE_CYCLE_EN drives gen_phase from rep_idx[1:0] (CYCLOPS).
module nmr_seq_fsm #(
  parameter int CNT_W      = 32,
  parameter int NUM_PULSES = 4,
  parameter int IDX_W      = 3,
  parameter int REP_W      = 16
) (
  input logic          clk,
  input logic          rst_n,
  nmr_seq_fsm_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_PULSE   = 3'd2,
    S_DELAY   = 3'd3,
    S_ACQ     = 3'd4,
    S_RECOVER = 3'd5,
    S_DONE    = 3'd6
  } state_e;

  localparam logic [CNT_W:0]   ONE_CW = (CNT_W+1)'(1);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);
  localparam logic [IDX_W:0]   ONE_IW = (IDX_W+1)'(1);
  localparam logic [IDX_W-1:0] ONE_I  = IDX_W'(1);
  localparam logic [IDX_W-1:0] MAX_P  = IDX_W'(NUM_PULSES);
  localparam logic [REP_W:0]   ONE_RW = (REP_W+1)'(1);
  localparam logic [REP_W-1:0] ONE_R  = REP_W'(1);

  state_e                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [CNT_W-1:0]            tr_cnt_q, tr_cnt_d;
  logic [IDX_W-1:0]            p_q, p_d;
  logic [REP_W-1:0]            rep_q, rep_d;
  logic                        start_prev_q, start_prev_d;
  logic                        start_rise_q, start_rise_d;

  logic [NUM_PULSES*CNT_W-1:0] plen_q, plen_d;
  logic [NUM_PULSES*CNT_W-1:0] dlen_q, dlen_d;
  logic [NUM_PULSES*16-1:0]    amp_sh_q, amp_sh_d;
  logic [IDX_W-1:0]            np_q, np_d;
  logic [CNT_W-1:0]            acq_q, acq_d;
  logic [CNT_W-1:0]            tr_q, tr_d;
  logic [REP_W-1:0]            nrep_q, nrep_d;

  logic                        en_gen_q, en_gen_d;
  logic [15:0]                 gen_amp_q, gen_amp_d;
  logic [31:0]                 gen_freq_q, gen_freq_d;
  logic                        rst_writer_q, rst_writer_d;
  logic                        rst_pck_q, rst_pck_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic                        err_q, err_d;

  logic [CNT_W-1:0]            cur_plen, cur_dlen, cur_len;
  logic [15:0]                 amp_sel;
  logic                        timer_done, tr_done, last_pulse, last_rep, np_valid;

  // Current-pulse length lookup and the end-of-interval comparisons, widened by one bit
  // so that +1 never wraps.
  always_comb begin
    cur_plen = '0;
    cur_dlen = '0;
    for (int i = 0; i < NUM_PULSES; i++) begin
      if (IDX_W'(i) == p_q) begin
        cur_plen = plen_q[i*CNT_W +: CNT_W];
        cur_dlen = dlen_q[i*CNT_W +: CNT_W];
      end
    end
    if (state_q == S_PULSE)      cur_len = cur_plen;
    else if (state_q == S_DELAY) cur_len = cur_dlen;
    else                         cur_len = acq_q;
    timer_done = ({1'b0, cnt_q} + ONE_CW) >= {1'b0, cur_len};
    tr_done    = ({1'b0, tr_cnt_q} + ONE_CW) >= {1'b0, tr_q};
    last_pulse = ({1'b0, p_q} + ONE_IW) >= {1'b0, np_q};
    last_rep   = ({1'b0, rep_q} + ONE_RW) >= {1'b0, nrep_q};
    np_valid   = (bus.cfg_n_pulses != '0) && (bus.cfg_n_pulses <= MAX_P);
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = '0;
    tr_cnt_d     = (&tr_cnt_q) ? tr_cnt_q : tr_cnt_q + ONE_C;
    p_d          = p_q;
    rep_d        = rep_q;
    start_prev_d = bus.start;
    start_rise_d = bus.start & ~start_prev_q;
    plen_d       = plen_q;
    dlen_d       = dlen_q;
    amp_sh_d     = amp_sh_q;
    np_d         = np_q;
    acq_d        = acq_q;
    tr_d         = tr_q;
    nrep_d       = nrep_q;
    gen_freq_d   = gen_freq_q;
    done_d       = done_q;
    err_d        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_rise_q && !bus.abort) begin
          if (np_valid) begin
            state_d    = S_SETUP;
            done_d     = 1'b0;
            plen_d     = bus.cfg_pulse_len;
            dlen_d     = bus.cfg_delay_len;
            amp_sh_d   = bus.cfg_amp;
            np_d       = bus.cfg_n_pulses;
            acq_d      = bus.cfg_acq_len;
            tr_d       = bus.cfg_tr;
            nrep_d     = (bus.cfg_n_rep == '0) ? ONE_R : bus.cfg_n_rep;
            gen_freq_d = bus.cfg_freq;
            p_d        = '0;
            rep_d      = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_SETUP: begin
        state_d  = S_PULSE;
        tr_cnt_d = '0;
      end
      S_PULSE: begin
        if (timer_done) state_d = S_DELAY;
        else            cnt_d   = cnt_q + ONE_C;
      end
      S_DELAY: begin
        if (!timer_done) begin
          cnt_d = cnt_q + ONE_C;
        end else if (last_pulse) begin
          state_d = S_ACQ;
        end else begin
          p_d     = p_q + ONE_I;
          state_d = S_PULSE;
        end
      end
      S_ACQ: begin
        if (timer_done) state_d = S_RECOVER;
        else            cnt_d   = cnt_q + ONE_C;
      end
      S_RECOVER: begin
        if (tr_done) begin
          if (last_rep) begin
            state_d = S_DONE;
          end else begin
            rep_d    = rep_q + ONE_R;
            p_d      = '0;
            tr_cnt_d = '0;
            state_d  = S_PULSE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort wins over every normal transition and freezes the pulse/rep indices.
    if (bus.abort && (state_q != S_IDLE) && (state_q != S_DONE)) begin
      state_d = S_DONE;
      p_d     = p_q;
      rep_d   = rep_q;
    end

    amp_sel = '0;
    for (int i = 0; i < NUM_PULSES; i++) begin
      if (IDX_W'(i) == p_d) amp_sel = amp_sh_q[i*16 +: 16];
    end

    en_gen_d     = (state_d == S_PULSE);
    gen_amp_d    = en_gen_d ? amp_sel : 16'h0000;
    rst_writer_d = (state_d != S_SETUP);
    rst_pck_d    = (state_d != S_ACQ);
    busy_d       = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      tr_cnt_q     <= '0;
      p_q          <= '0;
      rep_q        <= '0;
      start_prev_q <= 1'b0;
      start_rise_q <= 1'b0;
      plen_q       <= '0;
      dlen_q       <= '0;
      amp_sh_q     <= '0;
      np_q         <= '0;
      acq_q        <= '0;
      tr_q         <= '0;
      nrep_q       <= '0;
      en_gen_q     <= 1'b0;
      gen_amp_q    <= '0;
      gen_freq_q   <= '0;
      rst_writer_q <= 1'b1;
      rst_pck_q    <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tr_cnt_q     <= tr_cnt_d;
      p_q          <= p_d;
      rep_q        <= rep_d;
      start_prev_q <= start_prev_d;
      start_rise_q <= start_rise_d;
      plen_q       <= plen_d;
      dlen_q       <= dlen_d;
      amp_sh_q     <= amp_sh_d;
      np_q         <= np_d;
      acq_q        <= acq_d;
      tr_q         <= tr_d;
      nrep_q       <= nrep_d;
      en_gen_q     <= en_gen_d;
      gen_amp_q    <= gen_amp_d;
      gen_freq_q   <= gen_freq_d;
      rst_writer_q <= rst_writer_d;
      rst_pck_q    <= rst_pck_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign bus.en_gen     = en_gen_q;
  assign bus.gen_amp    = gen_amp_q;
  assign bus.gen_freq   = gen_freq_q;
  assign bus.rst_writer = rst_writer_q;
  assign bus.rst_pck    = rst_pck_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.rep_idx    = rep_q;
  assign bus.state      = state_q;

`ifdef NMR_SEQ_PHASE_CYCLE_EN
  assign bus.gen_phase = rep_q[1:0];
`else
  assign bus.gen_phase = 2'b00;
`endif

endmodule

// File: tb/tb_nmr_seq_fsm.sv
// Self-checking bench for nmr_seq_fsm: directed and random configs compared against an
// expected per-cycle trace built from the sequence rules.
module tb_nmr_seq_fsm;
  localparam int CNT_W      = 32;
  localparam int NUM_PULSES = 4;
  localparam int IDX_W      = 3;
  localparam int REP_W      = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  nmr_seq_fsm_if #(.CNT_W(CNT_W), .NUM_PULSES(NUM_PULSES), .IDX_W(IDX_W), .REP_W(REP_W)) bus ();

  nmr_seq_fsm #(.CNT_W(CNT_W), .NUM_PULSES(NUM_PULSES), .IDX_W(IDX_W), .REP_W(REP_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int st;
    int en;
    int amp;
    int pck;
    int wr;
    int rep;
  } cyc_t;

  cyc_t        trace[$];
  int          compared   = 0;
  int          mismatched = 0;
  int          m_np;
  int          m_plen[NUM_PULSES];
  int          m_dlen[NUM_PULSES];
  int          m_amp[NUM_PULSES];
  int          m_acq;
  int          m_tr;
  int          m_nrep;
  logic [31:0] m_freq;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int len_of(input int l);
    return (l < 1) ? 1 : l;
  endfunction

  task automatic push_cyc(input int st, input int en, input int amp, input int pck,
                          input int wr, input int rep);
    cyc_t c;
    c.st = st; c.en = en; c.amp = amp; c.pck = pck; c.wr = wr; c.rep = rep;
    trace.push_back(c);
  endtask

  // Expected trace: one SETUP, then per rep the pulse/delay pairs, acquisition and a
  // recovery pad that brings the rep up to TR cycles from its first pulse cycle.
  task automatic build_trace();
    int nrep;
    int e;
    int rec;
    trace.delete();
    push_cyc(1, 0, 0, 1, 0, 0);
    nrep = (m_nrep == 0) ? 1 : m_nrep;
    for (int r = 0; r < nrep; r++) begin
      e = 0;
      for (int p = 0; p < m_np; p++) begin
        for (int c = 0; c < len_of(m_plen[p]); c++) begin push_cyc(2, 1, m_amp[p], 1, 1, r); e++; end
        for (int c = 0; c < len_of(m_dlen[p]); c++) begin push_cyc(3, 0, 0, 1, 1, r); e++; end
      end
      for (int c = 0; c < len_of(m_acq); c++) begin push_cyc(4, 0, 0, 0, 1, r); e++; end
      rec = (m_tr > e) ? (m_tr - e) : 1;
      for (int c = 0; c < rec; c++) push_cyc(5, 0, 0, 1, 1, r);
    end
    push_cyc(6, 0, 0, 1, 1, nrep - 1);
  endtask

  task automatic applyStimulus();
    bus.cfg_n_pulses = IDX_W'(m_np);
    for (int i = 0; i < NUM_PULSES; i++) begin
      bus.cfg_pulse_len[i*CNT_W +: CNT_W] = m_plen[i];
      bus.cfg_delay_len[i*CNT_W +: CNT_W] = m_dlen[i];
      bus.cfg_amp[i*16 +: 16]             = 16'(m_amp[i]);
    end
    bus.cfg_freq    = m_freq;
    bus.cfg_acq_len = m_acq;
    bus.cfg_tr      = m_tr;
    bus.cfg_n_rep   = REP_W'(m_nrep);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic scramble_cfg();
    bus.cfg_n_pulses  = IDX_W'($urandom_range(1, NUM_PULSES));
    bus.cfg_pulse_len = {$urandom, $urandom, $urandom, $urandom};
    bus.cfg_delay_len = {$urandom, $urandom, $urandom, $urandom};
    bus.cfg_amp       = {$urandom, $urandom};
    bus.cfg_freq      = $urandom;
    bus.cfg_acq_len   = $urandom;
    bus.cfg_tr        = $urandom;
    bus.cfg_n_rep     = REP_W'($urandom);
  endtask

  task automatic run_trace(input int n_check, input bit repulse);
    int ph;
    for (int i = 0; i < n_check; i++) begin
      @(negedge clk);
`ifdef NMR_SEQ_PHASE_CYCLE_EN
      ph = trace[i].rep & 3;
`else
      ph = 0;
`endif
      checkOutput($sformatf("state@%0d", i), bus.state, trace[i].st);
      checkOutput($sformatf("en_gen@%0d", i), bus.en_gen, trace[i].en);
      checkOutput($sformatf("gen_amp@%0d", i), bus.gen_amp, trace[i].amp);
      checkOutput($sformatf("rst_pck@%0d", i), bus.rst_pck, trace[i].pck);
      checkOutput($sformatf("rst_writer@%0d", i), bus.rst_writer, trace[i].wr);
      checkOutput($sformatf("busy@%0d", i), bus.busy, 1);
      checkOutput($sformatf("err@%0d", i), bus.err, 0);
      checkOutput($sformatf("rep_idx@%0d", i), bus.rep_idx, trace[i].rep);
      checkOutput($sformatf("gen_phase@%0d", i), bus.gen_phase, ph);
      if (trace[i].st != 6) checkOutput($sformatf("done@%0d", i), bus.done, 0);
      if (trace[i].st == 2) checkOutput($sformatf("gen_freq@%0d", i), bus.gen_freq, m_freq);
      if (i == 1) scramble_cfg();
      if (repulse && i == 3) bus.start = 1'b1;
      if (repulse && i == 5) bus.start = 1'b0;
    end
  endtask

  task automatic check_idle_after(input string tag);
    @(negedge clk);
    checkOutput({tag, "_idle_state"}, bus.state, 0);
    checkOutput({tag, "_idle_busy"}, bus.busy, 0);
    checkOutput({tag, "_idle_done"}, bus.done, 1);
    checkOutput({tag, "_idle_en_gen"}, bus.en_gen, 0);
    checkOutput({tag, "_idle_rst_pck"}, bus.rst_pck, 1);
  endtask

  task automatic run_case(input string tag, input bit repulse);
    build_trace();
    applyStimulus();
    run_trace(trace.size(), repulse);
    check_idle_after(tag);
  endtask

  task automatic set_single_pulse();
    m_np = 1;
    for (int i = 0; i < NUM_PULSES; i++) begin m_plen[i] = 0; m_dlen[i] = 0; m_amp[i] = 0; end
    m_plen[0] = 10; m_dlen[0] = 5; m_amp[0] = 16'h1234;
    m_acq = 20; m_tr = 0; m_nrep = 1; m_freq = 32'h0BAD_F00D;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    set_single_pulse();
    scramble_cfg();
    repeat (3) @(negedge clk);
    checkOutput("rst_state", bus.state, 0);
    checkOutput("rst_en_gen", bus.en_gen, 0);
    checkOutput("rst_gen_amp", bus.gen_amp, 0);
    checkOutput("rst_gen_freq", bus.gen_freq, 0);
    checkOutput("rst_gen_phase", bus.gen_phase, 0);
    checkOutput("rst_rst_writer", bus.rst_writer, 1);
    checkOutput("rst_rst_pck", bus.rst_pck, 1);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_done", bus.done, 0);
    checkOutput("rst_err", bus.err, 0);
    checkOutput("rst_rep_idx", bus.rep_idx, 0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] single pulse with start re-pulsed while busy");
    set_single_pulse();
    run_case("single", 1'b1);

    $display("[TB] three-pulse train");
    m_np = 3;
    m_plen[0] = 4; m_plen[1] = 8; m_plen[2] = 4; m_plen[3] = 0;
    m_dlen[0] = 2; m_dlen[1] = 3; m_dlen[2] = 2; m_dlen[3] = 0;
    m_amp[0] = 100; m_amp[1] = 200; m_amp[2] = 300; m_amp[3] = 0;
    m_acq = 6; m_tr = 0; m_nrep = 1; m_freq = 32'h1357_9BDF;
    run_case("three", 1'b0);

    $display("[TB] three repetitions with TR=100");
    set_single_pulse();
    m_nrep = 3; m_tr = 100;
    run_case("reps", 1'b0);

    $display("[TB] zero lengths");
    m_np = 4;
    for (int i = 0; i < NUM_PULSES; i++) begin m_plen[i] = 0; m_dlen[i] = 0; m_amp[i] = 40 + i; end
    m_acq = 0; m_tr = 0; m_nrep = 2;
    run_case("zero", 1'b0);

    $display("[TB] invalid pulse counts");
    m_np = 0;
    applyStimulus();
    @(negedge clk);
    checkOutput("np0_err", bus.err, 1);
    checkOutput("np0_state", bus.state, 0);
    checkOutput("np0_busy", bus.busy, 0);
    @(negedge clk);
    checkOutput("np0_err_clear", bus.err, 0);
    checkOutput("np0_state_hold", bus.state, 0);
    m_np = 5;
    applyStimulus();
    @(negedge clk);
    checkOutput("np5_err", bus.err, 1);
    checkOutput("np5_state", bus.state, 0);
    checkOutput("np5_busy", bus.busy, 0);
    @(negedge clk);
    checkOutput("np5_err_clear", bus.err, 0);

    $display("[TB] abort held in IDLE blocks start");
    set_single_pulse();
    bus.abort = 1'b1;
    applyStimulus();
    @(negedge clk);
    checkOutput("abort_idle_state", bus.state, 0);
    checkOutput("abort_idle_busy", bus.busy, 0);
    checkOutput("abort_idle_err", bus.err, 0);
    @(negedge clk);
    checkOutput("abort_idle_state2", bus.state, 0);
    bus.abort = 1'b0;
    @(negedge clk);

    $display("[TB] abort in ACQ cycle 5");
    set_single_pulse();
    build_trace();
    applyStimulus();
    run_trace(1 + 10 + 5 + 5, 1'b0);
    bus.abort = 1'b1;
    @(negedge clk);
    checkOutput("abort_acq_state", bus.state, 6);
    checkOutput("abort_acq_rst_pck", bus.rst_pck, 1);
    checkOutput("abort_acq_en_gen", bus.en_gen, 0);
    checkOutput("abort_acq_busy", bus.busy, 1);
    bus.abort = 1'b0;
    check_idle_after("abort_acq");

    $display("[TB] random configurations");
    for (int k = 0; k < 8; k++) begin
      m_np = $urandom_range(1, NUM_PULSES);
      for (int i = 0; i < NUM_PULSES; i++) begin
        m_plen[i] = $urandom_range(0, 6);
        m_dlen[i] = $urandom_range(0, 6);
        m_amp[i]  = $urandom_range(0, 65535);
      end
      m_acq  = $urandom_range(0, 8);
      m_tr   = $urandom_range(0, 60);
      m_nrep = $urandom_range(0, 4);
      m_freq = $urandom;
      run_case($sformatf("rand%0d", k), 1'b0);
    end

    $display("[TB] reset mid-PULSE");
    set_single_pulse();
    build_trace();
    applyStimulus();
    run_trace(3, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midrst_state", bus.state, 0);
    checkOutput("midrst_en_gen", bus.en_gen, 0);
    checkOutput("midrst_gen_amp", bus.gen_amp, 0);
    checkOutput("midrst_busy", bus.busy, 0);
    checkOutput("midrst_done", bus.done, 0);
    checkOutput("midrst_gen_freq", bus.gen_freq, 0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
